bpred_table_ctrl: RTL

- Write-side sequencer for the 256-entry combined BTB/bimodal table (36-bit words, 4 byte lanes of 9 bits).
- After reset, clears the table. Then arbitrates between branch-resolution updates from execute (buffered in a small FIFO) and a configuration write port.
- Computes the saturating 2-bit counter update and the byte-enable/data packing.
- Drives the table's single write port; the read/lookup side is untouched.

---
 rtl/bpred_table_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bpred_table_ctrl.sv
// rtl/bpred_table_ctrl.sv - write-side sequencer for the combined BTB/bimodal table
module bpred_table_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int INDEX_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [31:0]        upd_pc4,
    input  logic [31:0]        upd_target,
    input  logic               upd_dir,
    input  logic               upd_miss,
    input  logic [1:0]         upd_bimodal,
    input  logic [8:0]         upd_carry,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [INDEX_W-1:0] cfg_index,
    input  logic [35:0]        cfg_data,
    output logic               mem_wren,
    output logic [INDEX_W-1:0] mem_wraddr,
    output logic [35:0]        mem_data,
    output logic [3:0]         mem_byteen,
    output logic               init_busy,
    output logic [15:0]        upd_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [INDEX_W-1:0] idx;
        logic [29:0]        target;
        logic               dir;
        logic               miss;
        logic [1:0]         bimodal;
        logic [8:0]         carry;
    } entry_t;

    state_t             state;
    logic [INDEX_W-1:0] init_idx;
    logic [SC_W-1:0]    starve_cnt;

    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    entry_t             head;
    entry_t             push_entry;
    logic               fifo_empty;
    logic               push;
    logic               cfg_grant;
    logic               upd_grant;
    logic [1:0]         next_ctr;
    logic [35:0]        upd_word;
    logic [3:0]         upd_be;

    assign upd_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = upd_valid && upd_ready;
    assign head       = fifo_mem[rd_ptr];

    assign push_entry = '{idx:     upd_pc4[INDEX_W+1:2],
                          target:  upd_target[31:2],
                          dir:     upd_dir,
                          miss:    upd_miss,
                          bimodal: upd_bimodal,
                          carry:   upd_carry};

    // Config wins when nothing is queued or it has waited STARVE_LIMIT update grants.
    assign cfg_grant = (state == S_RUN) && !stall && cfg_valid &&
                       (fifo_empty || starve_cnt == SC_W'(STARVE_LIMIT));
    assign upd_grant = (state == S_RUN) && !stall && !fifo_empty && !cfg_grant;
    assign cfg_ready = cfg_grant;

    always_comb begin
        next_ctr = head.bimodal;
        if (head.dir) begin
            if (head.bimodal != 2'd3) next_ctr = head.bimodal + 2'd1;
        end else begin
            if (head.bimodal != 2'd0) next_ctr = head.bimodal - 2'd1;
        end
    end

    // A taken mispredict rewrites the whole word with the new target; otherwise only lane 0 changes.
    always_comb begin
        upd_word = {27'b0, head.carry[8:6], next_ctr, head.carry[3:0]};
        upd_be   = 4'b0001;
        if (head.dir && head.miss) begin
            upd_word = {head.target, next_ctr, head.carry[3:0]};
            upd_be   = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_INIT;
            init_idx   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            upd_count  <= '0;
            mem_wren   <= 1'b0;
            mem_wraddr <= '0;
            mem_data   <= '0;
            mem_byteen <= '0;
            init_busy  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (upd_grant) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, upd_grant})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (!cfg_valid || cfg_grant) starve_cnt <= '0;
            else if (upd_grant)          starve_cnt <= starve_cnt + SC_W'(1);

            mem_wren <= 1'b0;
            case (state)
                S_INIT: begin
                    mem_wren   <= 1'b1;
                    mem_wraddr <= init_idx;
                    mem_data   <= '0;
                    mem_byteen <= 4'b1111;
                    init_idx   <= init_idx + INDEX_W'(1);
                    if (init_idx == '1) begin
                        state     <= S_RUN;
                        init_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cfg_grant) begin
                        mem_wren   <= 1'b1;
                        mem_wraddr <= cfg_index;
                        mem_data   <= cfg_data;
                        mem_byteen <= 4'b1111;
                    end else if (upd_grant) begin
                        mem_wren   <= 1'b1;
                        mem_wraddr <= head.idx;
                        mem_data   <= upd_word;
                        mem_byteen <= upd_be;
                        upd_count  <= upd_count + 16'd1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
